// File: rtl/lamp_switch_driver.sv
// rtl/lamp_switch_driver.sv - switch-side driver for the three-way lamp controller
// Toggles one switch line per request, waits to settle, then confirms lamp feedback.
module lamp_switch_driver #(
  parameter int SETTLE_CYC = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic             req_on,
  input  logic [1:0]       sel,
  input  logic             f_in,
  output logic [2:0]       s_out,
  output logic             busy,
  output logic             ack,
  output logic             err,
  output logic [CNT_W-1:0] toggle_cnt
);

  typedef enum logic [2:0] {IDLE, CHECK, SETTLE, CONFIRM, DONE} state_t;

  localparam logic [7:0] SETTLE_LD = 8'(SETTLE_CYC - 1);

  state_t           state, state_nx;
  logic             req_on_q, req_on_nx;
  logic [1:0]       sel_q, sel_nx;
  logic [7:0]       settle_q, settle_nx;
  logic [2:0]       s_out_nx;
  logic [CNT_W-1:0] cnt_nx;
  logic             busy_nx, ack_nx, err_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      req_on_q   <= 1'b0;
      sel_q      <= 2'd0;
      settle_q   <= 8'd0;
      s_out      <= 3'b000;
      toggle_cnt <= '0;
      busy       <= 1'b0;
      ack        <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_nx;
      req_on_q   <= req_on_nx;
      sel_q      <= sel_nx;
      settle_q   <= settle_nx;
      s_out      <= s_out_nx;
      toggle_cnt <= cnt_nx;
      busy       <= busy_nx;
      ack        <= ack_nx;
      err        <= err_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    req_on_nx = req_on_q;
    sel_nx    = sel_q;
    settle_nx = settle_q;
    s_out_nx  = s_out;
    cnt_nx    = toggle_cnt;
    err_nx    = 1'b0;

    case (state)
      IDLE: begin
        if (req) begin
          req_on_nx = req_on;
          sel_nx    = sel;
          state_nx  = CHECK;
        end
      end
      CHECK: begin
        if (sel_q == 2'd3) begin
          err_nx   = 1'b1;
          state_nx = DONE;
        end else if (f_in == req_on_q) begin
          state_nx = DONE;
        end else begin
          s_out_nx[sel_q] = ~s_out[sel_q];
          cnt_nx          = toggle_cnt + 1'b1;
          settle_nx       = SETTLE_LD;
          state_nx        = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_q == 8'd0) state_nx = CONFIRM;
        else settle_nx = settle_q - 8'd1;
      end
      CONFIRM: begin
        // The switch is left in its new position even when the lamp disagrees.
        err_nx   = (f_in != req_on_q);
        state_nx = DONE;
      end
      DONE: begin
        if (req) begin
          req_on_nx = req_on;
          sel_nx    = sel;
          state_nx  = CHECK;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    busy_nx = (state_nx == CHECK) || (state_nx == SETTLE) || (state_nx == CONFIRM);
    ack_nx  = (state_nx == DONE);
  end

endmodule
